// File: rtl/lstm_pkg.sv
// ============================================================================
// Module      : lstm_pkg
// Description : Shared types and default widths for the LSTM matrix-vector
//               sequencer (mac_seq) and its bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lstm_pkg;

    // Default widths for the sequencer bus
    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int WADDR_W = 16;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_seq_if.sv
// ============================================================================
// Module      : mac_seq_if
// Description : Request, memory-read and mac-control bundle of the mac_seq
//               sequencer. With MAC_SEQ_PERF_EN defined it also carries the
//               32-bit busy-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_seq_if #(
    parameter int IN_W    = lstm_pkg::IN_W,
    parameter int OUT_W   = lstm_pkg::OUT_W,
    parameter int WADDR_W = lstm_pkg::WADDR_W
);
    logic               req;
    logic [IN_W-1:0]    n_in;
    logic [OUT_W-1:0]   n_out;
    logic               busy;
    logic               done;
    logic [IN_W-1:0]    in_addr;
    logic [WADDR_W-1:0] w_addr;
    logic               mem_re;
    logic               mac_clr;
    logic               mac_en;
    logic               out_valid;
    logic [OUT_W-1:0]   out_idx;
`ifdef MAC_SEQ_PERF_EN
    logic [31:0]        cycles;
`endif

    // Requester side: issues jobs, observes the sequencer
    modport master (
        output req, n_in, n_out,
        input  busy, done, in_addr, w_addr, mem_re,
               mac_clr, mac_en, out_valid, out_idx
`ifdef MAC_SEQ_PERF_EN
        , input cycles
`endif
    );

    // Sequencer side
    modport slave (
        input  req, n_in, n_out,
        output busy, done, in_addr, w_addr, mem_re,
               mac_clr, mac_en, out_valid, out_idx
`ifdef MAC_SEQ_PERF_EN
        , output cycles
`endif
    );

endinterface

`default_nettype wire

// File: rtl/delay_line.sv
// ============================================================================
// Module      : delay_line
// Description : DEPTH-stage register pipe of WIDTH bits, synchronously
//               cleared to zero. Used to align flags with memory/mac latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    if (DEPTH == 1) begin : g_single
        // Single register stage
        always_ff @(posedge clk) begin
            if (rst) stage <= '0;
            else     stage <= din;
        end
    end else begin : g_multi
        // Shift the pipe by one stage per cycle, newest value in stage 0
        always_ff @(posedge clk) begin
            if (rst) stage <= '0;
            else     stage <= {stage[DEPTH-2:0], din};
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mac_seq.sv
// ============================================================================
// Module      : mac_seq
// Description : Sequencer for one W[n_out][n_in] * x[n_in] product on the mac
//               datapath. Issues one weight/input read per cycle, aligns the
//               mac clear/enable controls with memory latency and flags each
//               finished row after the mac latency.
//               Optional macro MAC_SEQ_PERF_EN adds a busy-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq #(
    parameter int IN_W    = lstm_pkg::IN_W,
    parameter int OUT_W   = lstm_pkg::OUT_W,
    parameter int WADDR_W = lstm_pkg::WADDR_W,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mac_seq_if.slave   bus
);
    import lstm_pkg::*;

    localparam int PIPE_LAT = MEM_LAT + MAC_LAT;
    localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);

    mac_seq_state_t     state, state_next;

    logic [IN_W-1:0]    n_in_q;
    logic [OUT_W-1:0]   n_out_q;
    logic               empty_q;
    logic [IN_W-1:0]    col;
    logic [OUT_W-1:0]   row;
    logic [WADDR_W-1:0] waddr;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               accept;
    logic               feed_rd;
    logic               col_last;
    logic               row_last;
    logic               first_rd;
    logic               last_rd;
    logic               drain_end;
    logic               mac_en_d;
    logic               mac_clr_d;
    logic               out_valid_d;
    logic [OUT_W-1:0]   out_idx_d;
    logic [OUT_W-1:0]   row_tag;

    assign accept    = (state == IDLE) && bus.req;
    // An empty job passes through FEED for one cycle without reading
    assign feed_rd   = (state == FEED) && !empty_q;
    assign col_last  = (col == n_in_q - IN_W'(1));
    assign row_last  = (row == n_out_q - OUT_W'(1));
    assign first_rd  = feed_rd && (col == '0);
    assign last_rd   = feed_rd && col_last;
    assign drain_end = (drain_cnt == DRAIN_W'(PIPE_LAT - 1));
    assign row_tag   = last_rd ? row : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req) state_next = FEED;
            FEED:    if (empty_q || (col_last && row_last)) state_next = empty_q ? DONE : DRAIN;
            DRAIN:   if (drain_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job dimensions are captured once per accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            n_in_q  <= '0;
            n_out_q <= '0;
            empty_q <= 1'b0;
        end else if (accept) begin
            n_in_q  <= bus.n_in;
            n_out_q <= bus.n_out;
            empty_q <= (bus.n_in == '0) || (bus.n_out == '0);
        end
    end

    // Column/row/weight-address counters advance on every read
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            col   <= '0;
            row   <= '0;
            waddr <= '0;
        end else if (feed_rd) begin
            waddr <= waddr + WADDR_W'(1);
            if (col_last) begin
                col <= '0;
                row <= row + OUT_W'(1);
            end else begin
                col <= col + IN_W'(1);
            end
        end
    end

    // Drain timer lets the last row emerge from the memory and mac pipes
    always_ff @(posedge clk) begin
        if (rst || (state != DRAIN)) drain_cnt <= '0;
        else                         drain_cnt <= drain_cnt + DRAIN_W'(1);
    end

    delay_line #(
        .WIDTH (2),
        .DEPTH (MEM_LAT)
    ) u_issue_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({feed_rd, first_rd}),
        .dout ({mac_en_d, mac_clr_d})
    );

    delay_line #(
        .WIDTH (1 + OUT_W),
        .DEPTH (PIPE_LAT)
    ) u_result_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({last_rd, row_tag}),
        .dout ({out_valid_d, out_idx_d})
    );

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mem_re    = feed_rd;
    assign bus.in_addr   = feed_rd ? col   : '0;
    assign bus.w_addr    = feed_rd ? waddr : '0;
    assign bus.mac_en    = mac_en_d;
    assign bus.mac_clr   = mac_clr_d;
    assign bus.out_valid = out_valid_d;
    assign bus.out_idx   = out_idx_d;

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] cycle_cnt;

    // Busy-cycle counter: cleared by a new job, frozen while idle
    always_ff @(posedge clk) begin
        if (rst || accept)      cycle_cnt <= '0;
        else if (state != IDLE) cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign bus.cycles = cycle_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_seq.sv
// ============================================================================
// Module      : tb_mac_seq
// Description : Directed testbench for mac_seq. Expected reads, mac controls,
//               row results and done pulses are queued when a job is issued
//               and compared cycle-by-cycle as the sequencer produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_seq;

    localparam int IN_W    = 8;
    localparam int OUT_W   = 8;
    localparam int WADDR_W = 16;
    localparam int ML      = 1;
    localparam int AL      = 2;

    typedef struct {
        int cyc;
        int a;
        int b;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t rd_q[$];
    exp_t mac_q[$];
    exp_t out_q[$];
    exp_t done_q[$];

    mac_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W), .WADDR_W(WADDR_W)) bus ();

    mac_seq #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .WADDR_W (WADDR_W),
        .MEM_LAT (ML),
        .MAC_LAT (AL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},      32'(bus.busy),      0);
        chk({tag, "_done"},      32'(bus.done),      0);
        chk({tag, "_mem_re"},    32'(bus.mem_re),    0);
        chk({tag, "_mac_en"},    32'(bus.mac_en),    0);
        chk({tag, "_mac_clr"},   32'(bus.mac_clr),   0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_in_addr"},   32'(bus.in_addr),   0);
        chk({tag, "_w_addr"},    32'(bus.w_addr),    0);
        chk({tag, "_out_idx"},   32'(bus.out_idx),   0);
    endtask

    // Issue a job in cycle 0 and queue everything it should produce
    task automatic start_job(input int ni, input int no);
        int base;
        int k;
        @(negedge clk); #1;
        bus.req   = 1'b1;
        bus.n_in  = ni[IN_W-1:0];
        bus.n_out = no[OUT_W-1:0];
        base = cyc;
        if (ni == 0 || no == 0) begin
            done_q.push_back('{base + 2, 0, 0});
        end else begin
            for (int r = 0; r < no; r++) begin
                for (int c = 0; c < ni; c++) begin
                    k = r * ni + c;
                    rd_q.push_back('{base + 1 + k, k, c});
                    mac_q.push_back('{base + 1 + ML + k, (c == 0) ? 1 : 0, 0});
                    if (c == ni - 1) out_q.push_back('{base + 1 + ML + AL + k, r, 0});
                end
            end
            done_q.push_back('{base + ni * no + ML + AL + 1, 0, 0});
        end
        @(negedge clk); #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.done), 1);
    endtask

    // Scoreboard: every observed event must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_re === 1'b1) begin
            if (rd_q.size() == 0) chk("read_unexpected", 32'(bus.mem_re), 0);
            else begin
                e = rd_q.pop_front();
                chk("read_cycle", cyc, e.cyc);
                chk("w_addr", 32'(bus.w_addr), e.a);
                chk("in_addr", 32'(bus.in_addr), e.b);
            end
        end
        if (bus.mac_en === 1'b1) begin
            if (mac_q.size() == 0) chk("mac_en_unexpected", 32'(bus.mac_en), 0);
            else begin
                e = mac_q.pop_front();
                chk("mac_cycle", cyc, e.cyc);
                chk("mac_clr", 32'(bus.mac_clr), e.a);
            end
        end
        if (bus.out_valid === 1'b1) begin
            if (out_q.size() == 0) chk("out_valid_unexpected", 32'(bus.out_valid), 0);
            else begin
                e = out_q.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("out_idx", 32'(bus.out_idx), e.a);
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(bus.done), 0);
            else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.n_in  = '0;
        bus.n_out = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        #1 rst = 1'b0;

        // Reference job 3x2
        start_job(3, 2);
        chk("busy_in_feed", 32'(bus.busy), 1);
        wait_done("done_3x2");
`ifdef MAC_SEQ_PERF_EN
        @(negedge clk);
        chk("cycles_after_done", bus.cycles, 10);
        repeat (3) @(negedge clk);
        chk("cycles_hold", bus.cycles, 10);
`endif

        // Single-input rows: a result every cycle
        start_job(1, 4);
        wait_done("done_1x4");

        // Empty jobs
        start_job(0, 5);
        wait_done("done_0x5");
        start_job(4, 0);
        wait_done("done_4x0");
`ifdef MAC_SEQ_PERF_EN
        @(negedge clk);
        chk("cycles_empty", bus.cycles, 2);
`endif

        // Request during FEED is ignored, then a back-to-back job
        start_job(3, 2);
        @(negedge clk); #1;
        bus.req   = 1'b1;
        bus.n_in  = 8'd7;
        bus.n_out = 8'd7;
        @(negedge clk); #1;
        bus.req   = 1'b0;
        wait_done("done_ignored_req");
        start_job(2, 3);
        wait_done("done_back_to_back");

        // Reset in the middle of a job
        start_job(4, 4);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        rd_q.delete();
        mac_q.delete();
        out_q.delete();
        done_q.delete();
        @(negedge clk);
        chk_quiet("mid_reset");
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_abort", 32'(bus.busy), 0);

        // Recovery after abort
        start_job(2, 2);
        wait_done("done_after_abort");
        repeat (3) @(negedge clk);

        chk("rd_q_left",   rd_q.size(),   0);
        chk("mac_q_left",  mac_q.size(),  0);
        chk("out_q_left",  out_q.size(),  0);
        chk("done_q_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
